// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings and defaults for the multiply/divide unit.
// MDUOp encodings, FSM states, default latency/counter widths, HI/LO read select.
package mdu_pkg;

   typedef enum logic [2:0] {
      MDU_NONE  = 3'd0,
      MDU_MULT  = 3'd1,
      MDU_MULTU = 3'd2,
      MDU_DIV   = 3'd3,
      MDU_DIVU  = 3'd4,
      MDU_MTHI  = 3'd5,
      MDU_MTLO  = 3'd6,
      MDU_RSVD  = 3'd7
   } mdu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   localparam int MDU_MULT_CYCLES_DEF = 5;
   localparam int MDU_DIV_CYCLES_DEF  = 10;
   localparam int MDU_CNT_W_DEF       = 4;

   localparam logic HILO_SEL_HI = 1'b1;
   localparam logic HILO_SEL_LO = 1'b0;

   // Two's complement negation of a 32-bit word (0x80000000 maps to itself).
   function automatic logic [31:0] neg32(input logic [31:0] v);
      return 32'd0 - v;
   endfunction

endpackage

// File: rtl/mdu.sv
// mdu: multiply/divide unit for the E stage of the MIPS pipeline.
// mult/multu/div/divu compute their result at accept into pending registers;
// a down-counter models the latency and HI/LO are written on the last busy edge.
// mthi/mtlo write HI/LO in a single cycle. Out is the mfhi/mflo read mux.
// Optional build macro: MDU_TRACE_EN enables a writeback trace of HI/LO writes.
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF,
   parameter int CNT_W       = MDU_CNT_W_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [2:0]  MDUOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        HiLoSel,
   input  logic [31:0] WPC,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] Out
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

   // state
   mdu_state_e       state_q, state_d;
   logic             busy_q,  busy_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [31:0]      hi_q,    hi_d;
   logic [31:0]      lo_q,    lo_d;
   logic [31:0]      ph_q,    ph_d;
   logic [31:0]      pl_q,    pl_d;
   logic             wr_en_q, wr_en_d;

   // decode
   mdu_op_e          op_s;
   logic             is_mul_s;
   logic             is_div_s;
   logic             is_mt_s;
   logic             idle_s;
   logic             accept_s;
   logic             mt_wr_s;
   logic             commit_s;

   // datapath
   logic [63:0]      mul_a_s;
   logic [63:0]      mul_b_s;
   logic [63:0]      prod_s;
   logic             div_signed_s;
   logic             div_zero_s;
   logic [31:0]      div_a_mag_s;
   logic [31:0]      div_b_mag_s;
   logic [31:0]      div_b_safe_s;
   logic [31:0]      quo_mag_s;
   logic [31:0]      rem_mag_s;
   logic [31:0]      quo_s;
   logic [31:0]      rem_s;
   logic [31:0]      res_hi_s;
   logic [31:0]      res_lo_s;

   assign op_s     = mdu_op_e'(MDUOp);
   assign idle_s   = (state_q == ST_IDLE);
   assign accept_s = Start & idle_s & (is_mul_s | is_div_s);
   assign mt_wr_s  = Start & idle_s & is_mt_s;
   assign commit_s = (state_q == ST_RUN) & (cnt_q == CNT_ONE);

   // Classify the opcode; NONE and the reserved code fall into no class.
   always_comb begin
      is_mul_s = 1'b0;
      is_div_s = 1'b0;
      is_mt_s  = 1'b0;
      case (op_s)
         MDU_MULT, MDU_MULTU: is_mul_s = 1'b1;
         MDU_DIV,  MDU_DIVU:  is_div_s = 1'b1;
         MDU_MTHI, MDU_MTLO:  is_mt_s  = 1'b1;
         default:             is_mul_s = 1'b0;
      endcase
   end

   // 64-bit product: operands are sign- or zero-extended so one multiplier serves both forms.
   always_comb begin
      if (op_s == MDU_MULT) begin
         mul_a_s = {{32{A[31]}}, A};
         mul_b_s = {{32{B[31]}}, B};
      end else begin
         mul_a_s = {32'd0, A};
         mul_b_s = {32'd0, B};
      end
      prod_s = mul_a_s * mul_b_s;
   end

   // Divide on magnitudes, then restore signs: quotient truncates toward zero,
   // remainder follows the dividend. A zero divisor is replaced to keep the
   // operator defined; that result is never committed.
   always_comb begin
      div_signed_s = (op_s == MDU_DIV);
      div_zero_s   = (B == 32'd0);
      div_a_mag_s  = (div_signed_s && A[31]) ? neg32(A) : A;
      div_b_mag_s  = (div_signed_s && B[31]) ? neg32(B) : B;
      div_b_safe_s = div_zero_s ? 32'd1 : div_b_mag_s;
      quo_mag_s    = div_a_mag_s / div_b_safe_s;
      rem_mag_s    = div_a_mag_s % div_b_safe_s;
      quo_s        = (div_signed_s && (A[31] ^ B[31])) ? neg32(quo_mag_s) : quo_mag_s;
      rem_s        = (div_signed_s && A[31]) ? neg32(rem_mag_s) : rem_mag_s;
   end

   // Pick the pending HI/LO words for the accepted operation.
   always_comb begin
      if (is_mul_s) begin
         res_hi_s = prod_s[63:32];
         res_lo_s = prod_s[31:0];
      end else if (is_div_s) begin
         res_hi_s = rem_s;
         res_lo_s = quo_s;
      end else begin
         res_hi_s = 32'd0;
         res_lo_s = 32'd0;
      end
   end

   // FSM next state: accept or mthi/mtlo in IDLE, count down and commit in RUN.
   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      ph_d    = ph_q;
      pl_d    = pl_q;
      wr_en_d = wr_en_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               ph_d    = res_hi_s;
               pl_d    = res_lo_s;
               wr_en_d = ~(is_div_s & div_zero_s);
               cnt_d   = is_mul_s ? CNT_MULT : CNT_DIV;
               state_d = ST_RUN;
               busy_d  = 1'b1;
            end else if (mt_wr_s) begin
               if (op_s == MDU_MTHI) begin
                  hi_d = A;
               end else begin
                  lo_d = A;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Start is ignored here; the in-flight operation runs to completion.
            if (cnt_q == CNT_ONE) begin
               if (wr_en_q) begin
                  hi_d = ph_q;
                  lo_d = pl_q;
               end else begin
                  hi_d = hi_q;
               end
               cnt_d   = CNT_ZERO;
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // State registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         cnt_q   <= CNT_ZERO;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         ph_q    <= 32'd0;
         pl_q    <= 32'd0;
         wr_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         ph_q    <= ph_d;
         pl_q    <= pl_d;
         wr_en_q <= wr_en_d;
      end
   end

   assign Busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;
   assign Out  = (HiLoSel == HILO_SEL_HI) ? hi_q : lo_q;

`ifdef MDU_TRACE_EN
   logic [31:0] wpc_q, wpc_d;

   // Hold the PC of the accepted mult/div so the commit trace names its instruction.
   always_comb begin
      if (accept_s) begin
         wpc_d = WPC;
      end else begin
         wpc_d = wpc_q;
      end
   end

   // PC latch register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wpc_q <= 32'd0;
      end else begin
         wpc_q <= wpc_d;
      end
   end

   // Writeback-style trace of every HI/LO write.
   always @(posedge clk) begin
      if (!reset) begin
         if (commit_s && wr_en_q) begin
            $display("@%h: $hi <= %h", wpc_q, ph_q);
            $display("@%h: $lo <= %h", wpc_q, pl_q);
         end else if (mt_wr_s) begin
            if (op_s == MDU_MTHI) begin
               $display("@%h: $hi <= %h", WPC, A);
            end else begin
               $display("@%h: $lo <= %h", WPC, A);
            end
         end else begin
         end
      end
   end
`else
   logic unused_wpc_s;
   assign unused_wpc_s = ^WPC;
`endif

endmodule
